// File: rtl/ref_sram_pkg.sv
// rtl/ref_sram_pkg.sv - shared sizes and FSM state type for the reference-window buffer
package ref_sram_pkg;
    localparam int PIX_W  = 8;
    localparam int WIN    = 23;
    localparam int IN_PIX = 8;
    localparam int WPR    = (WIN + IN_PIX - 1) / IN_PIX;
    localparam int ROW_W  = WIN * PIX_W;
    localparam int IN_W   = IN_PIX * PIX_W;
    localparam int CNT_W  = 5;
    localparam int WORD_W = 2;

    localparam logic [CNT_W-1:0]  LAST_ROW  = CNT_W'(WIN - 1);
    localparam logic [CNT_W-1:0]  ROW_END   = CNT_W'(WIN);
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WPR - 1);

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        STREAM = 2'd1,
        NEXT   = 2'd2
    } state_t;
endpackage

// File: rtl/ref_sram_rowbuf.sv
// rtl/ref_sram_rowbuf.sv - WIN x ROW_W window storage, byte-lane word writes, one-row read port
module ref_sram_rowbuf
    import ref_sram_pkg::*;
(
    input  logic              clk,
    input  logic              wr_en,
    input  logic [CNT_W-1:0]  wr_row,
    input  logic [WORD_W-1:0] wr_word,
    input  logic [IN_W-1:0]   wr_data,
    input  logic [CNT_W-1:0]  rd_row,
    output logic [ROW_W-1:0]  rd_data
);
    logic [ROW_W-1:0] mem [WIN];

    // Column c lives in word c/IN_PIX, lane c%IN_PIX; lanes past the last column are dropped.
    always_ff @(posedge clk) begin
        for (int c = 0; c < WIN; c++) begin
            if (wr_en && wr_word == WORD_W'(c / IN_PIX)) begin
                mem[wr_row][c*PIX_W +: PIX_W] <= wr_data[(c % IN_PIX)*PIX_W +: PIX_W];
            end
        end
    end

    assign rd_data = mem[rd_row];
endmodule

// File: rtl/ref_sram.sv
// rtl/ref_sram.sv - search-window loader/replayer for the ME array
// Optional REF_SRAM_OUT_REG_EN adds one register stage on ref_out/sram_ready/next_block.
module ref_sram
    import ref_sram_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  ref_in,
    output logic             read_en,
    output logic [ROW_W-1:0] ref_out,
    output logic             sram_ready,
    output logic             next_block
);
    state_t            state_q, state_d;
    logic [WORD_W-1:0] w_q, w_d;
    logic [CNT_W-1:0]  r_q, r_d;
    logic [CNT_W-1:0]  rd_q, rd_d;
    logic              read_en_q, read_en_d;
    logic              rdy_q, rdy_d;
    logic              nb_q, nb_d;
    logic              out_load;
    logic              wr_en;
    logic [ROW_W-1:0]  row_data;
    logic [ROW_W-1:0]  ref_q;

    assign wr_en = read_en_q && !rst;

    ref_sram_rowbuf u_rowbuf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_row  (r_q),
        .wr_word (w_q),
        .wr_data (ref_in),
        .rd_row  (rd_q),
        .rd_data (row_data)
    );

    always_comb begin
        state_d   = state_q;
        w_d       = w_q;
        r_d       = r_q;
        rd_d      = rd_q;
        read_en_d = read_en_q;
        rdy_d     = rdy_q;
        nb_d      = nb_q;
        out_load  = 1'b0;
        case (state_q)
            LOAD: begin
                if (!read_en_q) begin
                    read_en_d = 1'b1;
                end else if (w_q == LAST_WORD) begin
                    w_d = '0;
                    if (r_q == LAST_ROW) begin
                        r_d       = '0;
                        rd_d      = '0;
                        read_en_d = 1'b0;
                        state_d   = STREAM;
                    end else begin
                        r_d = r_q + 1'b1;
                    end
                end else begin
                    w_d = w_q + 1'b1;
                end
            end
            STREAM: begin
                if (rd_q != ROW_END) begin
                    out_load = 1'b1;
                    rdy_d    = 1'b1;
                    rd_d     = rd_q + 1'b1;
                end else begin
                    rdy_d   = 1'b0;
                    nb_d    = 1'b1;
                    state_d = NEXT;
                end
            end
            NEXT: begin
                nb_d      = 1'b0;
                read_en_d = 1'b1;
                w_d       = '0;
                r_d       = '0;
                rd_d      = '0;
                state_d   = LOAD;
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= LOAD;
            w_q       <= '0;
            r_q       <= '0;
            rd_q      <= '0;
            read_en_q <= 1'b0;
            rdy_q     <= 1'b0;
            nb_q      <= 1'b0;
            ref_q     <= '0;
        end else begin
            state_q   <= state_d;
            w_q       <= w_d;
            r_q       <= r_d;
            rd_q      <= rd_d;
            read_en_q <= read_en_d;
            rdy_q     <= rdy_d;
            nb_q      <= nb_d;
            if (out_load) begin
                ref_q <= row_data;
            end
        end
    end

    assign read_en = read_en_q;

`ifdef REF_SRAM_OUT_REG_EN
    logic [ROW_W-1:0] ref_q2;
    logic             rdy_q2;
    logic             nb_q2;

    always_ff @(posedge clk) begin
        if (rst) begin
            ref_q2 <= '0;
            rdy_q2 <= 1'b0;
            nb_q2  <= 1'b0;
        end else begin
            ref_q2 <= ref_q;
            rdy_q2 <= rdy_q;
            nb_q2  <= nb_q;
        end
    end

    assign ref_out    = ref_q2;
    assign sram_ready = rdy_q2;
    assign next_block = nb_q2;
`else
    assign ref_out    = ref_q;
    assign sram_ready = rdy_q;
    assign next_block = nb_q;
`endif
endmodule

// File: tb/tb_ref_sram.sv
// tb/tb_ref_sram.sv - directed self-checking bench for ref_sram (honours REF_SRAM_OUT_REG_EN)
module tb_ref_sram;
`ifdef REF_SRAM_OUT_REG_EN
    localparam int D = 1;
`else
    localparam int D = 0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [63:0]  ref_in = '0;
    logic         read_en;
    logic [183:0] ref_out;
    logic         sram_ready;
    logic         next_block;

    int total = 0;
    int bad   = 0;
    int e     = 0;
    int word_idx = 0;
    bit toggle_in = 1'b0;

    ref_sram dut (
        .clk        (clk),
        .rst        (rst),
        .ref_in     (ref_in),
        .read_en    (read_en),
        .ref_out    (ref_out),
        .sram_ready (sram_ready),
        .next_block (next_block)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [183:0] got, input logic [183:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at E%0d: got %h expected %h", tag, e, got, exp);
        end
    endtask

    function automatic logic [63:0] make_word(input int n);
        logic [63:0] v;
        for (int i = 0; i < 8; i++) v[8*i +: 8] = 8'((8*n + i) % 256);
        return v;
    endfunction

    function automatic logic [183:0] row_exp(input int base, input int row);
        logic [183:0] v;
        for (int k = 0; k < 23; k++) v[8*k +: 8] = 8'((base + 24*row + k) % 256);
        return v;
    endfunction

    // One rising edge; the source advances only on edges that saw read_en high.
    task automatic step();
        logic re;
        re = read_en;
        @(posedge clk);
        #1;
        if (!rst) begin
            e++;
            if (re) word_idx++;
        end
        if (rst && toggle_in) ref_in = {$urandom, $urandom};
        else ref_in = make_word(word_idx);
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) step();
        rst = 1'b0;
        e = 0;
        word_idx = 0;
        ref_in = make_word(0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".read_en"}, 184'(read_en), 184'(0));
        chk({tag, ".sram_ready"}, 184'(sram_ready), 184'(0));
        chk({tag, ".next_block"}, 184'(next_block), 184'(0));
        chk({tag, ".ref_out"}, ref_out, 184'(0));
    endtask

    // Runs edges up to origin+96 and checks the window timeline relative to origin.
    task automatic run_window(input int o, input int base);
        int rel;
        while (e < o + 96) begin
            step();
            rel = e - o;
            if (rel == 1 || rel == 2 || rel == 69) chk("read_en_on", 184'(read_en), 184'(1));
            if (rel == 70 || rel == 80 || rel == 94) chk("read_en_off", 184'(read_en), 184'(0));
            if (rel == 95) chk("read_en_again", 184'(read_en), 184'(1));
            if (rel == 70 + D || rel == 94 + D) chk("ready_low", 184'(sram_ready), 184'(0));
            if (rel >= 71 + D && rel <= 93 + D) begin
                chk("ready_high", 184'(sram_ready), 184'(1));
                chk($sformatf("row%0d", rel - 71 - D), ref_out, row_exp(base, rel - 71 - D));
            end
            if (rel == 93 + D || rel == 95 + D) chk("nb_low", 184'(next_block), 184'(0));
            if (rel == 94 + D) begin
                chk("nb_pulse", 184'(next_block), 184'(1));
                chk("ref_hold", ref_out, row_exp(base, 22));
            end
        end
    endtask

    initial begin
        @(negedge clk);
        // Test 1-3: reset state, first window, second window continuous
        do_reset(2);
        chk_zero("reset");
        run_window(0, 0);
        run_window(94, 552);

        // Test 4: reset asserted in STREAM at E80
        do_reset(1);
        while (e < 79) step();
        rst = 1'b1;
        step();
        chk_zero("mid_rst");
        rst = 1'b0;
        e = 0;
        word_idx = 0;
        ref_in = make_word(0);
        run_window(0, 0);

        // Test 5: long reset with a toggling source
        toggle_in = 1'b1;
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk_zero("hold_rst");
        end
        toggle_in = 1'b0;
        rst = 1'b0;
        e = 0;
        word_idx = 0;
        ref_in = make_word(0);
        run_window(0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
